de2_sram_ctrl: RTL

- Bridges the SoC's 32-bit single-outstanding data-memory request bus to the DE2 board's external 256K x 16 asynchronous SRAM.
- Each 32-bit access becomes up to two sequenced 16-bit SRAM phases: low halfword first, then high halfword.
- Owns all SRAM control strobes, the halfword address and the tristate data bus.
- Sits between the data-bus interconnect and the top-level SRAM pins.

---
 rtl/de2_sram_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/de2_sram_ctrl.sv
// 32-bit request bus to 256Kx16 async SRAM bridge; read = 2*ACC_CYCLES+1 cycles to rsp_valid, single-half write = ACC_CYCLES+1.
// Backpressure: req_ready low from handshake through RESP, so a held request simply waits for IDLE.
module de2_sram_ctrl #(
    parameter int ACC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [18:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byteen,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic        sram_ce_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    localparam logic [3:0] LAST = 4'(ACC_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        wr, wr_nx;
    logic [31:0] wdata, wdata_nx;
    logic [3:0]  be, be_nx;
    logic [16:0] waddr, waddr_nx;
    logic [17:0] addr_nx;
    logic        we_nx, oe_nx, ub_nx, lb_nx, ce_nx;
    logic        data_oe, data_oe_nx;
    logic [15:0] data_out, data_out_nx;
    logic        phase_hi;

    wire unused_addr_lsb = &{1'b0, req_addr[1:0]};

    assign req_ready = (state == IDLE);
    assign sram_data = data_oe ? data_out : 16'hzzzz;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr_nx    = wr;
        wdata_nx = wdata;
        be_nx    = be;
        waddr_nx = waddr;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    wr_nx    = req_write;
                    wdata_nx = req_wdata;
                    be_nx    = req_byteen;
                    waddr_nx = req_addr[18:2];
                    cnt_nx   = 4'd0;
                    if (!req_write || (req_byteen[1:0] != 2'b00))
                        state_nx = LO;
                    else if (req_byteen[3:2] != 2'b00)
                        state_nx = HI;
                    else
                        state_nx = RESP;
                end
            end
            LO: begin
                if (cnt == LAST) begin
                    cnt_nx   = 4'd0;
                    state_nx = (!wr || (be[3:2] != 2'b00)) ? HI : RESP;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            HI: begin
                if (cnt == LAST) begin
                    cnt_nx   = 4'd0;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pin values are derived from the next state so the registered pins line up with the phase itself.
    always_comb begin
        addr_nx     = sram_addr;
        we_nx       = 1'b1;
        oe_nx       = 1'b1;
        ub_nx       = 1'b1;
        lb_nx       = 1'b1;
        ce_nx       = 1'b1;
        data_oe_nx  = 1'b0;
        data_out_nx = data_out;
        phase_hi    = (state_nx == HI);
        if ((state_nx == LO) || (state_nx == HI)) begin
            addr_nx = {waddr_nx, phase_hi};
            ce_nx   = 1'b0;
            if (wr_nx) begin
                data_oe_nx  = 1'b1;
                data_out_nx = phase_hi ? wdata_nx[31:16] : wdata_nx[15:0];
                lb_nx       = phase_hi ? !be_nx[2] : !be_nx[0];
                ub_nx       = phase_hi ? !be_nx[3] : !be_nx[1];
                we_nx       = (cnt_nx == LAST);
            end else begin
                oe_nx = 1'b0;
                ub_nx = 1'b0;
                lb_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr        <= 1'b0;
            wdata     <= 32'd0;
            be        <= 4'd0;
            waddr     <= 17'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            sram_addr <= 18'd0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ce_n <= 1'b1;
            data_oe   <= 1'b0;
            data_out  <= 16'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            wr        <= wr_nx;
            wdata     <= wdata_nx;
            be        <= be_nx;
            waddr     <= waddr_nx;
            rsp_valid <= (state_nx == RESP);
            sram_addr <= addr_nx;
            sram_we_n <= we_nx;
            sram_oe_n <= oe_nx;
            sram_ub_n <= ub_nx;
            sram_lb_n <= lb_nx;
            sram_ce_n <= ce_nx;
            data_oe   <= data_oe_nx;
            data_out  <= data_out_nx;
            // Cleared on accept so a write response carries zero data.
            if ((state == IDLE) && req_valid)
                rsp_rdata <= 32'd0;
            else if (!wr && (cnt == LAST) && (state == LO))
                rsp_rdata[15:0] <= sram_data;
            else if (!wr && (cnt == LAST) && (state == HI))
                rsp_rdata[31:16] <= sram_data;
        end
    end

endmodule
